// File: rtl/divider_pkg.sv
// Shared RV32M definitions: funct3 encodings, divider FSM states and the
// result constants used for the architecturally defined corner cases.
package m_extension;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } m_funct3;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } div_state_t;

    localparam int          DIV_ITER      = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift the partial remainder
// left by one quotient bit and subtract the divisor if it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic [XLEN-1:0] next_quo
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // The extra top bit keeps 2*rem+1 exact; trial's MSB is its sign.
    assign shifted = {rem, quo[XLEN-1]};
    assign trial   = shifted - {1'b0, divisor};

    always_comb begin
        next_quo = {quo[XLEN-2:0], ~trial[XLEN]};
        next_rem = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    end

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish at once.
module divider
    import m_extension::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  m_funct3         funct3,
    input  logic            div_start,
    input  logic            flush,
    output logic            div_busy,
    output logic            div_done,
    output logic [XLEN-1:0] div_out
);

    div_state_t      state;
    logic            op_rem;
    logic            sign_q;
    logic            sign_r;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [CNT_W-1:0] cnt;

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            accept;
    logic            div_zero;
    logic            overflow;
    logic            last_iter;
    logic [XLEN-1:0] next_rem;
    logic [XLEN-1:0] next_quo;
    logic [XLEN-1:0] q_fixed;
    logic [XLEN-1:0] r_fixed;

    // funct3[0] set means the unsigned variant; magnitudes of INT_MIN stay 0x80000000.
    assign is_signed = ~funct3[0];
    assign a_neg     = is_signed & rs1_data[XLEN-1];
    assign b_neg     = is_signed & rs2_data[XLEN-1];
    assign a_mag     = a_neg ? -rs1_data : rs1_data;
    assign b_mag     = b_neg ? -rs2_data : rs2_data;
    assign accept    = div_start & funct3[2] & (state == IDLE) & ~flush;
    assign div_zero  = (rs2_data == '0);
    assign overflow  = is_signed & (rs1_data == INT_MIN) & (rs2_data == '1);
    assign last_iter = (cnt == CNT_W'(DIV_ITER - 1));
    assign q_fixed   = sign_q ? -next_quo : next_quo;
    assign r_fixed   = sign_r ? -next_rem : next_rem;
    assign div_busy  = (state == CALC);

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .next_rem (next_rem),
        .next_quo (next_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_rem   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            divisor  <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            div_done <= 1'b0;
            div_out  <= '0;
        end else begin
            div_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            div_out  <= funct3[1] ? rs1_data : DIV_BY_ZERO_Q;
                            div_done <= 1'b1;
                        end else if (overflow) begin
                            div_out  <= funct3[1] ? '0 : INT_MIN;
                            div_done <= 1'b1;
                        end else begin
                            state   <= CALC;
                            op_rem  <= funct3[1];
                            sign_q  <= a_neg ^ b_neg;
                            sign_r  <= a_neg;
                            divisor <= b_mag;
                            quo     <= a_mag;
                            rem     <= '0;
                            cnt     <= '0;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        rem <= next_rem;
                        quo <= next_quo;
                        cnt <= cnt + 1'b1;
                        // Final iteration: register the sign-corrected result directly.
                        if (last_iter) begin
                            state    <= IDLE;
                            div_out  <= op_rem ? r_fixed : q_fixed;
                            div_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
